// File: rtl/vdp_super_res_writer_pkg.sv
// Shared types for the super-res CPU-side VRAM writer: pointer/word widths,
// the queued write entry, the issue FSM states and the byte-lane helper.
package vdp_super_res_writer_pkg;

   localparam int SUPER_RES_PTR_W  = 19;
   localparam int VRAM_WORD_ADDR_W = 17;

   typedef struct packed {
      logic [SUPER_RES_PTR_W-1:0] ptr;
      logic [7:0]                 data;
   } super_wr_entry_t;

   typedef enum logic [1:0] {
      SW_IDLE,
      SW_ISSUE,
      SW_WAIT_ACK
   } super_wr_state_t;

   // Pixel n lives in byte n of the linear layout, so lane 0 is wdata[7:0].
   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/vdp_super_res_writer_if.sv
// VRAM write port between the super-res writer (master) and the VRAM arbiter (slave).
interface vdp_super_res_writer_if;
   import vdp_super_res_writer_pkg::*;

   logic                        vram_wr_req;
   logic [VRAM_WORD_ADDR_W-1:0] vram_addr;
   logic [31:0]                 vram_wdata;
   logic [3:0]                  vram_be;
   logic                        vram_ack;

   modport master (
      output vram_wr_req, vram_addr, vram_wdata, vram_be,
      input  vram_ack
   );

   modport slave (
      input  vram_wr_req, vram_addr, vram_wdata, vram_be,
      output vram_ack
   );

endinterface

// File: rtl/vdp_super_wr_fifo.sv
// Small synchronous FIFO of pending byte writes. A push while full is still
// accepted when a pop happens in the same cycle.
module vdp_super_wr_fifo
   import vdp_super_res_writer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  super_wr_entry_t wr_entry,
   output super_wr_entry_t rd_entry,
   output logic            full,
   output logic            empty
);

   localparam int IDX_W = $clog2(DEPTH);

   // Extra MSB on each index distinguishes full from empty.
   logic [IDX_W:0]  wr_idx;
   logic [IDX_W:0]  rd_idx;
   super_wr_entry_t mem [DEPTH];
   logic            do_push;
   logic            do_pop;

   assign empty   = (wr_idx == rd_idx);
   assign full    = (wr_idx[IDX_W] != rd_idx[IDX_W]) &&
                    (wr_idx[IDX_W-1:0] == rd_idx[IDX_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_entry = mem[rd_idx[IDX_W-1:0]];

   // Read/write index advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx <= '0;
         rd_idx <= '0;
      end else begin
         if (do_push) wr_idx <= wr_idx + 1'b1;
         if (do_pop)  rd_idx <= rd_idx + 1'b1;
      end
   end

   // Entry storage; contents need no reset since the indices define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx[IDX_W-1:0]] <= wr_entry;
   end

endmodule

// File: rtl/vdp_super_res_writer.sv
// CPU-side writer into the linear 8bpp super-res framebuffer. The CPU loads a
// byte pointer, then streams pixel bytes that auto-increment it; each byte is
// committed as a byte-enabled 32-bit VRAM write only while the display is not
// fetching.
module vdp_super_res_writer
   import vdp_super_res_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = SUPER_RES_PTR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   vdp_super,
   input  logic                   super_res_drawing,
   input  logic                   cpu_ptr_wr,
   input  logic [1:0]             cpu_ptr_sel,
   input  logic                   cpu_data_wr,
   input  logic [7:0]             cpu_data,
   vdp_super_res_writer_if.master vram,
   output logic                   fifo_full,
   output logic                   busy,
   output logic                   overflow,
   input  logic                   status_rd
);

   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W-1:0]   ptr_next;
   super_wr_state_t     state;
   super_wr_state_t     state_next;
   super_wr_entry_t     push_entry;
   super_wr_entry_t     head;
   logic                fifo_empty;
   logic                pop;
   logic                push_ok;
   logic                req;
   logic [ADDR_W-3:0]   addr;
   logic [31:0]         wdata;
   logic [3:0]          be;

   // Only start a new write from IDLE with the gate open; an in-flight write is never aborted.
   assign pop     = (state == SW_IDLE) && !fifo_empty && vdp_super && !super_res_drawing;
   assign push_ok = cpu_data_wr && (!fifo_full || pop);
   assign push_entry.ptr  = ptr;
   assign push_entry.data = cpu_data;
   assign busy = !fifo_empty || (state != SW_IDLE);

   assign vram.vram_wr_req = req;
   assign vram.vram_addr   = addr;
   assign vram.vram_wdata  = wdata;
   assign vram.vram_be     = be;

   vdp_super_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_ok),
      .pop      (pop),
      .wr_entry (push_entry),
      .rd_entry (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Pointer update: data auto-increment first, then a pointer byte load overrides its own byte.
   always_comb begin
      ptr_next = ptr;
      if (push_ok) ptr_next = ptr + 1'b1;
      if (cpu_ptr_wr) begin
         case (cpu_ptr_sel)
            2'd0:    ptr_next[7:0]         = cpu_data;
            2'd1:    ptr_next[15:8]        = cpu_data;
            2'd2:    ptr_next[ADDR_W-1:16] = cpu_data[ADDR_W-17:0];
            default: ;
         endcase
      end
   end

   // Pointer and sticky overflow; a drop in the same cycle as status_rd keeps overflow set.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr      <= '0;
         overflow <= 1'b0;
      end else begin
         ptr <= ptr_next;
         if (cpu_data_wr && !push_ok) overflow <= 1'b1;
         else if (status_rd)          overflow <= 1'b0;
      end
   end

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= SW_IDLE;
      else       state <= state_next;
   end

   // Issue FSM next-state.
   always_comb begin
      state_next = state;
      case (state)
         SW_IDLE:     if (pop) state_next = SW_ISSUE;
         SW_ISSUE:    state_next = SW_WAIT_ACK;
         SW_WAIT_ACK: if (vram.vram_ack) state_next = SW_IDLE;
         default:     state_next = SW_IDLE;
      endcase
   end

   // Registered VRAM request; address, data and lanes are captured at pop and held until ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         req   <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         be    <= '0;
      end else begin
         req <= (state_next != SW_IDLE);
         if (pop) begin
            addr  <= head.ptr[ADDR_W-1:2];
            wdata <= {4{head.data}};
            be    <= lane_be(head.ptr[1:0]);
         end
      end
   end

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Directed bench for vdp_super_res_writer: stimulus pushes expected VRAM writes
// into a queue, a monitor pops and compares on each new request, and an arbiter
// model acknowledges after a programmable delay.
module tb_vdp_super_res_writer;
   import vdp_super_res_writer_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       vdp_super;
   logic       super_res_drawing;
   logic       cpu_ptr_wr;
   logic [1:0] cpu_ptr_sel;
   logic       cpu_data_wr;
   logic [7:0] cpu_data;
   logic       fifo_full;
   logic       busy;
   logic       overflow;
   logic       status_rd;

   always #5 clk = ~clk;

   vdp_super_res_writer_if vram_if();

   vdp_super_res_writer dut (
      .clk               (clk),
      .reset             (reset),
      .vdp_super         (vdp_super),
      .super_res_drawing (super_res_drawing),
      .cpu_ptr_wr        (cpu_ptr_wr),
      .cpu_ptr_sel       (cpu_ptr_sel),
      .cpu_data_wr       (cpu_data_wr),
      .cpu_data          (cpu_data),
      .vram              (vram_if.master),
      .fifo_full         (fifo_full),
      .busy              (busy),
      .overflow          (overflow),
      .status_rd         (status_rd)
   );

   typedef struct packed {
      logic [16:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   ack_delay = 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   // Arbiter model: ack arrives ack_delay cycles after the request enters WAIT_ACK.
   initial begin
      int cnt;
      cnt = 0;
      vram_if.vram_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (vram_if.vram_wr_req && !vram_if.vram_ack) begin
            cnt++;
            if (cnt > ack_delay) begin
               vram_if.vram_ack = 1'b1;
               cnt = 0;
            end
         end else begin
            vram_if.vram_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: compare each new request with the queue head, then demand it stays stable.
   initial begin
      logic prev_req;
      exp_t cur;
      exp_t e;
      prev_req = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (vram_if.vram_wr_req && !prev_req) begin
            cur.addr  = vram_if.vram_addr;
            cur.be    = vram_if.vram_be;
            cur.wdata = vram_if.vram_wdata;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_req: addr 0x%0h be %b wdata 0x%0h with nothing expected",
                        cur.addr, cur.be, cur.wdata);
            end else begin
               e = exp_q.pop_front();
               check("vram_addr",  64'(cur.addr),  64'(e.addr));
               check("vram_be",    64'(cur.be),    64'(e.be));
               check("vram_wdata", 64'(cur.wdata), 64'(e.wdata));
            end
         end else if (vram_if.vram_wr_req && prev_req) begin
            check("req_held_stable",
                  64'({vram_if.vram_addr, vram_if.vram_be, vram_if.vram_wdata}), 64'(cur));
         end
         prev_req = vram_if.vram_wr_req;
      end
   end

   // Stimulus tasks are entered on a falling edge and return on the next one.
   task automatic ptr_wr(input logic [1:0] sel, input logic [7:0] v);
      cpu_ptr_wr = 1'b1;
      cpu_ptr_sel = sel;
      cpu_data = v;
      @(negedge clk);
      cpu_ptr_wr = 1'b0;
   endtask

   task automatic set_ptr(input logic [18:0] p);
      ptr_wr(2'd0, p[7:0]);
      ptr_wr(2'd1, p[15:8]);
      ptr_wr(2'd2, {5'b0, p[18:16]});
   endtask

   task automatic data_wr(input logic [7:0] v, input bit expect_push,
                          input logic [16:0] a, input logic [3:0] lanes);
      exp_t e;
      cpu_data_wr = 1'b1;
      cpu_data = v;
      if (expect_push) begin
         e.addr = a;
         e.be = lanes;
         e.wdata = {4{v}};
         exp_q.push_back(e);
      end
      @(negedge clk);
      cpu_data_wr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || vram_if.vram_wr_req) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < 300), 64'd1);
   endtask

   task automatic wait_req(input string name, input logic level);
      int n;
      n = 0;
      while (vram_if.vram_wr_req !== level && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < 50), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      vdp_super = 1'b0;
      super_res_drawing = 1'b0;
      cpu_ptr_wr = 1'b0;
      cpu_ptr_sel = 2'd0;
      cpu_data_wr = 1'b0;
      cpu_data = 8'h00;
      status_rd = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req",      64'(vram_if.vram_wr_req), 64'd0);
      check("reset_addr",     64'(vram_if.vram_addr),   64'd0);
      check("reset_wdata",    64'(vram_if.vram_wdata),  64'd0);
      check("reset_be",       64'(vram_if.vram_be),     64'd0);
      check("reset_full",     64'(fifo_full),           64'd0);
      check("reset_busy",     64'(busy),                64'd0);
      check("reset_overflow", 64'(overflow),            64'd0);
      reset = 1'b0;
      vdp_super = 1'b1;
      @(negedge clk);

      // Pointer 0x51234: word 0x1448D lane 0, then auto-incremented to lane 1.
      set_ptr(19'h51234);
      data_wr(8'hAB, 1'b1, 17'h1448D, 4'b0001);
      data_wr(8'hCD, 1'b1, 17'h1448D, 4'b0010);
      wait_idle("idle_after_first");

      // Four bytes from ptr 2 cross a word boundary.
      set_ptr(19'h00002);
      data_wr(8'h11, 1'b1, 17'h0, 4'b0100);
      data_wr(8'h22, 1'b1, 17'h0, 4'b1000);
      data_wr(8'h33, 1'b1, 17'h1, 4'b0001);
      data_wr(8'h44, 1'b1, 17'h1, 4'b0010);
      wait_idle("idle_after_burst");
      check("no_overflow_burst", 64'(overflow), 64'd0);

      // Display owns VRAM: four queue, the fifth is dropped and flags overflow.
      super_res_drawing = 1'b1;
      set_ptr(19'h00000);
      data_wr(8'h50, 1'b1, 17'h0, 4'b0001);
      data_wr(8'h51, 1'b1, 17'h0, 4'b0010);
      data_wr(8'h52, 1'b1, 17'h0, 4'b0100);
      data_wr(8'h53, 1'b1, 17'h0, 4'b1000);
      data_wr(8'h54, 1'b0, 17'h0, 4'b0000);
      repeat (4) @(negedge clk);
      check("gated_full",     64'(fifo_full),           64'd1);
      check("gated_overflow", 64'(overflow),            64'd1);
      check("gated_no_req",   64'(vram_if.vram_wr_req), 64'd0);
      check("gated_busy",     64'(busy),                64'd1);
      super_res_drawing = 1'b0;
      wait_idle("idle_after_gate");
      check("overflow_sticky", 64'(overflow), 64'd1);
      status_rd = 1'b1;
      @(negedge clk);
      status_rd = 1'b0;
      check("overflow_cleared", 64'(overflow), 64'd0);
      // The dropped byte left the pointer at 4.
      data_wr(8'h60, 1'b1, 17'h1, 4'b0001);
      wait_idle("idle_after_ptr4");

      // Pointer wrap at the top of the 19-bit space.
      set_ptr(19'h7FFFF);
      data_wr(8'h77, 1'b1, 17'h1FFFF, 4'b1000);
      data_wr(8'h88, 1'b1, 17'h00000, 4'b0001);
      wait_idle("idle_after_wrap");

      // Slow ack with the display taking over mid-transaction.
      ack_delay = 10;
      data_wr(8'h99, 1'b1, 17'h0, 4'b0010);
      data_wr(8'hAA, 1'b1, 17'h0, 4'b0100);
      wait_req("slow_req_rise", 1'b1);
      super_res_drawing = 1'b1;
      wait_req("slow_req_fall", 1'b0);
      repeat (4) @(negedge clk);
      check("held_off_no_req", 64'(vram_if.vram_wr_req), 64'd0);
      check("held_off_busy",   64'(busy),                64'd1);
      super_res_drawing = 1'b0;
      wait_idle("idle_after_slow");

      // Reset while waiting for ack.
      ack_delay = 20;
      data_wr(8'hEE, 1'b1, 17'h0, 4'b1000);
      wait_req("reset_case_req", 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_req",  64'(vram_if.vram_wr_req), 64'd0);
      check("midreset_busy", 64'(busy),                64'd0);
      check("midreset_full", 64'(fifo_full),           64'd0);
      reset = 1'b0;
      ack_delay = 1;
      @(negedge clk);
      data_wr(8'h42, 1'b1, 17'h0, 4'b0001);
      wait_idle("idle_after_reset");

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
